// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values
// and the dispenser state encoding.
package vm_pkg;

    // Coin codes presented to the ejector
    localparam logic [1:0] MOEDA_NENHUMA = 2'b00;
    localparam logic [1:0] MOEDA_25      = 2'b01;
    localparam logic [1:0] MOEDA_50      = 2'b10;
    localparam logic [1:0] MOEDA_100     = 2'b11;

    // Coin values in cents
    localparam int VALOR_25  = 25;
    localparam int VALOR_50  = 50;
    localparam int VALOR_100 = 100;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESCOLHE = 2'd1,
        EMITE   = 2'd2,
        FIM     = 2'd3
    } estado_troco_t;

endpackage

// File: rtl/seletor_moeda.sv
// Greedy coin chooser: picks the largest coin that still fits in the
// remaining amount and is available in the local wallet copy.
module seletor_moeda
    import vm_pkg::*;
#(
    parameter int W_VALOR = 8,
    parameter int W_CONT  = 8
) (
    input  logic [W_VALOR-1:0] restante,
    input  logic [W_CONT-1:0]  cont_25,
    input  logic [W_CONT-1:0]  cont_50,
    input  logic [W_CONT-1:0]  cont_100,
    output logic [1:0]         codigo,
    output logic [W_VALOR-1:0] valor,
    output logic               achou
);

    // Priority from largest to smallest denomination
    always_comb begin
        codigo = MOEDA_NENHUMA;
        valor  = '0;
        achou  = 1'b0;
        if (restante >= W_VALOR'(VALOR_100) && cont_100 != '0) begin
            codigo = MOEDA_100;
            valor  = W_VALOR'(VALOR_100);
            achou  = 1'b1;
        end else if (restante >= W_VALOR'(VALOR_50) && cont_50 != '0) begin
            codigo = MOEDA_50;
            valor  = W_VALOR'(VALOR_50);
            achou  = 1'b1;
        end else if (restante >= W_VALOR'(VALOR_25) && cont_25 != '0) begin
            codigo = MOEDA_25;
            valor  = W_VALOR'(VALOR_25);
            achou  = 1'b1;
        end
    end

endmodule

// File: rtl/dispensador_troco.sv
// Change dispenser: ejects coins largest-first over a valid/accept
// handshake and reports coins used and any unpaid remainder.
// Optional EMITE watchdog enabled by defining DISPENSADOR_TIMEOUT_EN.
module dispensador_troco
    import vm_pkg::*;
#(
    parameter int W_VALOR = 8,
    parameter int W_CONT  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               iniciar,
    input  logic [W_VALOR-1:0] valor_troco,
    input  logic [W_CONT-1:0]  moedas_carteira_25,
    input  logic [W_CONT-1:0]  moedas_carteira_50,
    input  logic [W_CONT-1:0]  moedas_carteira_100,
    output logic               moeda_pronta,
    output logic [1:0]         moeda_tipo,
    input  logic               moeda_aceita,
    output logic               ocupado,
    output logic               concluido,
    output logic               erro_troco,
    output logic [W_VALOR-1:0] troco_falta,
    output logic [W_CONT-1:0]  usadas_25,
    output logic [W_CONT-1:0]  usadas_50,
    output logic [W_CONT-1:0]  usadas_100
);

    estado_troco_t      estado_reg, estado_next;
    logic [W_VALOR-1:0] restante_reg, restante_next;
    logic [W_VALOR-1:0] valor_moeda_reg, valor_moeda_next;
    logic [W_CONT-1:0]  cont_25_reg, cont_25_next;
    logic [W_CONT-1:0]  cont_50_reg, cont_50_next;
    logic [W_CONT-1:0]  cont_100_reg, cont_100_next;
    logic [W_CONT-1:0]  usadas_25_reg, usadas_25_next;
    logic [W_CONT-1:0]  usadas_50_reg, usadas_50_next;
    logic [W_CONT-1:0]  usadas_100_reg, usadas_100_next;
    logic               erro_reg, erro_next;
    logic [W_VALOR-1:0] falta_reg, falta_next;
    logic               pronta_reg, pronta_next;
    logic [1:0]         tipo_reg, tipo_next;
`ifdef DISPENSADOR_TIMEOUT_EN
    logic [7:0]         wd_reg, wd_next;
`endif

    logic [1:0]         sel_codigo;
    logic [W_VALOR-1:0] sel_valor;
    logic               sel_achou;

    seletor_moeda #(
        .W_VALOR (W_VALOR),
        .W_CONT  (W_CONT)
    ) u_seletor (
        .restante (restante_reg),
        .cont_25  (cont_25_reg),
        .cont_50  (cont_50_reg),
        .cont_100 (cont_100_reg),
        .codigo   (sel_codigo),
        .valor    (sel_valor),
        .achou    (sel_achou)
    );

    // State and datapath registers; reset drops any coin on offer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_reg      <= OCIOSO;
            restante_reg    <= '0;
            valor_moeda_reg <= '0;
            cont_25_reg     <= '0;
            cont_50_reg     <= '0;
            cont_100_reg    <= '0;
            usadas_25_reg   <= '0;
            usadas_50_reg   <= '0;
            usadas_100_reg  <= '0;
            erro_reg        <= 1'b0;
            falta_reg       <= '0;
            pronta_reg      <= 1'b0;
            tipo_reg        <= MOEDA_NENHUMA;
`ifdef DISPENSADOR_TIMEOUT_EN
            wd_reg          <= '0;
`endif
        end else begin
            estado_reg      <= estado_next;
            restante_reg    <= restante_next;
            valor_moeda_reg <= valor_moeda_next;
            cont_25_reg     <= cont_25_next;
            cont_50_reg     <= cont_50_next;
            cont_100_reg    <= cont_100_next;
            usadas_25_reg   <= usadas_25_next;
            usadas_50_reg   <= usadas_50_next;
            usadas_100_reg  <= usadas_100_next;
            erro_reg        <= erro_next;
            falta_reg       <= falta_next;
            pronta_reg      <= pronta_next;
            tipo_reg        <= tipo_next;
`ifdef DISPENSADOR_TIMEOUT_EN
            wd_reg          <= wd_next;
`endif
        end
    end

    // Next-state and datapath updates for the dispensing sequence
    always_comb begin
        estado_next      = estado_reg;
        restante_next    = restante_reg;
        valor_moeda_next = valor_moeda_reg;
        cont_25_next     = cont_25_reg;
        cont_50_next     = cont_50_reg;
        cont_100_next    = cont_100_reg;
        usadas_25_next   = usadas_25_reg;
        usadas_50_next   = usadas_50_reg;
        usadas_100_next  = usadas_100_reg;
        erro_next        = erro_reg;
        falta_next       = falta_reg;
        pronta_next      = pronta_reg;
        tipo_next        = tipo_reg;
`ifdef DISPENSADOR_TIMEOUT_EN
        wd_next          = wd_reg;
`endif
        case (estado_reg)
            OCIOSO: begin
                if (iniciar) begin
                    restante_next   = valor_troco;
                    cont_25_next    = moedas_carteira_25;
                    cont_50_next    = moedas_carteira_50;
                    cont_100_next   = moedas_carteira_100;
                    usadas_25_next  = '0;
                    usadas_50_next  = '0;
                    usadas_100_next = '0;
                    erro_next       = 1'b0;
                    falta_next      = '0;
                    estado_next     = ESCOLHE;
                end
            end
            ESCOLHE: begin
                if (sel_achou) begin
                    tipo_next        = sel_codigo;
                    valor_moeda_next = sel_valor;
                    pronta_next      = 1'b1;
                    estado_next      = EMITE;
`ifdef DISPENSADOR_TIMEOUT_EN
                    wd_next          = '0;
`endif
                end else begin
                    falta_next  = restante_reg;
                    erro_next   = (restante_reg != '0);
                    estado_next = FIM;
                end
            end
            EMITE: begin
                if (moeda_aceita) begin
                    // Chosen coin never exceeds restante, so no underflow
                    restante_next = restante_reg - valor_moeda_reg;
                    case (tipo_reg)
                        MOEDA_25: begin
                            cont_25_next   = cont_25_reg - W_CONT'(1);
                            usadas_25_next = usadas_25_reg + W_CONT'(1);
                        end
                        MOEDA_50: begin
                            cont_50_next   = cont_50_reg - W_CONT'(1);
                            usadas_50_next = usadas_50_reg + W_CONT'(1);
                        end
                        MOEDA_100: begin
                            cont_100_next   = cont_100_reg - W_CONT'(1);
                            usadas_100_next = usadas_100_reg + W_CONT'(1);
                        end
                        default: ;
                    endcase
                    pronta_next = 1'b0;
                    tipo_next   = MOEDA_NENHUMA;
                    estado_next = ESCOLHE;
`ifdef DISPENSADOR_TIMEOUT_EN
                    wd_next     = '0;
`endif
                end
`ifdef DISPENSADOR_TIMEOUT_EN
                else if (wd_reg == 8'd254) begin
                    // 255th stalled cycle: give up on the ejector
                    erro_next   = 1'b1;
                    falta_next  = restante_reg;
                    pronta_next = 1'b0;
                    tipo_next   = MOEDA_NENHUMA;
                    estado_next = FIM;
                end else begin
                    wd_next = wd_reg + 8'd1;
                end
`endif
            end
            FIM: begin
                estado_next = OCIOSO;
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    assign moeda_pronta = pronta_reg;
    assign moeda_tipo   = tipo_reg;
    assign ocupado      = (estado_reg != OCIOSO);
    assign concluido    = (estado_reg == FIM);
    assign erro_troco   = erro_reg;
    assign troco_falta  = falta_reg;
    assign usadas_25    = usadas_25_reg;
    assign usadas_50    = usadas_50_reg;
    assign usadas_100   = usadas_100_reg;

endmodule

// File: tb/tb_dispensador_troco.sv
// Self-checking bench for dispensador_troco: table of change transactions
// plus hand sequences for stall, reset mid-transaction and (with
// DISPENSADOR_TIMEOUT_EN) the EMITE watchdog.
module tb_dispensador_troco;

    logic       clock;
    logic       reset_n;
    logic       iniciar;
    logic [7:0] valor_troco;
    logic [7:0] moedas_carteira_25, moedas_carteira_50, moedas_carteira_100;
    logic       moeda_pronta;
    logic [1:0] moeda_tipo;
    logic       moeda_aceita;
    logic       ocupado, concluido, erro_troco;
    logic [7:0] troco_falta;
    logic [7:0] usadas_25, usadas_50, usadas_100;

    int n_cmp = 0;
    int n_bad = 0;

    dispensador_troco #(.W_VALOR(8), .W_CONT(8)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .iniciar             (iniciar),
        .valor_troco         (valor_troco),
        .moedas_carteira_25  (moedas_carteira_25),
        .moedas_carteira_50  (moedas_carteira_50),
        .moedas_carteira_100 (moedas_carteira_100),
        .moeda_pronta        (moeda_pronta),
        .moeda_tipo          (moeda_tipo),
        .moeda_aceita        (moeda_aceita),
        .ocupado             (ocupado),
        .concluido           (concluido),
        .erro_troco          (erro_troco),
        .troco_falta         (troco_falta),
        .usadas_25           (usadas_25),
        .usadas_50           (usadas_50),
        .usadas_100          (usadas_100)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Coin sequence packed left to right: first coin in bits [15:14]
    typedef struct {
        logic [7:0]  valor;
        logic [7:0]  c25, c50, c100;
        int          n_moedas;
        logic [15:0] seq;
        logic [7:0]  u25, u50, u100;
        logic [7:0]  falta;
        logic        erro;
    } vec_t;

    vec_t tabela [7];

    task automatic chk(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nome, atual, esperado);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".pronta"},     int'(moeda_pronta), 0);
        chk({tag, ".tipo"},       int'(moeda_tipo),   0);
        chk({tag, ".ocupado"},    int'(ocupado),      0);
        chk({tag, ".concluido"},  int'(concluido),    0);
        chk({tag, ".erro"},       int'(erro_troco),   0);
        chk({tag, ".falta"},      int'(troco_falta),  0);
        chk({tag, ".usadas_25"},  int'(usadas_25),    0);
        chk({tag, ".usadas_50"},  int'(usadas_50),    0);
        chk({tag, ".usadas_100"}, int'(usadas_100),   0);
    endtask

    task automatic start(input logic [7:0] v, input logic [7:0] a25,
                         input logic [7:0] a50, input logic [7:0] a100);
        @(negedge clock);
        iniciar             = 1'b1;
        valor_troco         = v;
        moedas_carteira_25  = a25;
        moedas_carteira_50  = a50;
        moedas_carteira_100 = a100;
    endtask

    // One full transaction with moeda_aceita as set by the caller
    task automatic do_txn(input vec_t v, input string tag);
        logic [1:0] got [$];
        logic [1:0] esp;
        logic [15:0] seq;
        bit done;
        done = 1'b0;
        seq  = v.seq;
        start(v.valor, v.c25, v.c50, v.c100);
        @(negedge clock);
        // First busy cycle: previous results cleared; a new iniciar is ignored
        chk({tag, ".busy"},     int'(ocupado),    1);
        chk({tag, ".clr_erro"}, int'(erro_troco), 0);
        chk({tag, ".clr_u100"}, int'(usadas_100), 0);
        iniciar     = 1'b1;
        valor_troco = 8'd25;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            iniciar = 1'b0;
            if (moeda_pronta && moeda_aceita) got.push_back(moeda_tipo);
            if (concluido) done = 1'b1;
        end
        chk({tag, ".done"}, int'(done), 1);
        @(negedge clock);
        chk({tag, ".pulse1"}, int'(concluido), 0);
        chk({tag, ".idle"},   int'(ocupado),   0);
        repeat (2) @(negedge clock);
        chk({tag, ".ncoins"}, got.size(), v.n_moedas);
        for (int i = 0; i < v.n_moedas && i < got.size(); i++) begin
            esp = seq[15 - 2*i -: 2];
            chk($sformatf("%s.coin%0d", tag, i), int'(got[i]), int'(esp));
        end
        chk({tag, ".u25"},   int'(usadas_25),   int'(v.u25));
        chk({tag, ".u50"},   int'(usadas_50),   int'(v.u50));
        chk({tag, ".u100"},  int'(usadas_100),  int'(v.u100));
        chk({tag, ".falta"}, int'(troco_falta), int'(v.falta));
        chk({tag, ".erro"},  int'(erro_troco),  int'(v.erro));
        $display("txn %s valor=%0d coins=%0d u=%0d/%0d/%0d falta=%0d erro=%0d",
                 tag, v.valor, got.size(), usadas_25, usadas_50, usadas_100,
                 troco_falta, erro_troco);
    endtask

    initial begin
        int n_stall;
        bit done;
        vec_t v50;

        //          valor  c25 c50 c100 n  seq                      u25 u50 u100 falta erro
        tabela[0] = '{8'd175, 8'd5, 8'd5, 8'd5, 3, 16'b11_10_01_00_00_00_00_00, 8'd1, 8'd1, 8'd1, 8'd0,   1'b0};
        tabela[1] = '{8'd150, 8'd4, 8'd1, 8'd0, 5, 16'b10_01_01_01_01_00_00_00, 8'd4, 8'd1, 8'd0, 8'd0,   1'b0};
        tabela[2] = '{8'd130, 8'd5, 8'd5, 8'd5, 2, 16'b11_01_00_00_00_00_00_00, 8'd1, 8'd0, 8'd1, 8'd5,   1'b1};
        tabela[3] = '{8'd0,   8'd5, 8'd5, 8'd5, 0, 16'b0,                       8'd0, 8'd0, 8'd0, 8'd0,   1'b0};
        tabela[4] = '{8'd255, 8'd5, 8'd5, 8'd5, 3, 16'b11_11_10_00_00_00_00_00, 8'd0, 8'd1, 8'd2, 8'd5,   1'b1};
        tabela[5] = '{8'd75,  8'd3, 8'd0, 8'd5, 3, 16'b01_01_01_00_00_00_00_00, 8'd3, 8'd0, 8'd0, 8'd0,   1'b0};
        tabela[6] = '{8'd200, 8'd0, 8'd0, 8'd0, 0, 16'b0,                       8'd0, 8'd0, 8'd0, 8'd200, 1'b1};

        reset_n = 1'b0;
        iniciar = 1'b0;
        valor_troco = '0;
        moedas_carteira_25 = '0;
        moedas_carteira_50 = '0;
        moedas_carteira_100 = '0;
        moeda_aceita = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Table-driven transactions with the ejector always accepting
        moeda_aceita = 1'b1;
        for (int i = 0; i < 7; i++) do_txn(tabela[i], $sformatf("vec%0d", i));

        // Stall: ejector holds off 6 cycles, coin must stay stable
        moeda_aceita = 1'b0;
        start(8'd100, 8'd5, 8'd5, 8'd5);
        @(negedge clock);
        iniciar = 1'b0;
        chk("stall.escolhe_pronta", int'(moeda_pronta), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("stall.pronta%0d", i), int'(moeda_pronta), 1);
            chk($sformatf("stall.tipo%0d", i),   int'(moeda_tipo),   3);
            chk($sformatf("stall.u100_%0d", i),  int'(usadas_100),   0);
        end
        moeda_aceita = 1'b1;
        @(negedge clock);
        chk("stall.pronta_drop", int'(moeda_pronta), 0);
        chk("stall.u100",        int'(usadas_100),   1);
        @(negedge clock);
        chk("stall.concluido", int'(concluido),   1);
        chk("stall.falta",     int'(troco_falta), 0);
        chk("stall.erro",      int'(erro_troco),  0);
        $display("txn stall valor=100 u100=%0d erro=%0d", usadas_100, erro_troco);

        // Reset while the second coin is on offer
        moeda_aceita = 1'b0;
        start(8'd175, 8'd5, 8'd5, 8'd5);
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        moeda_aceita = 1'b1;
        @(negedge clock);
        moeda_aceita = 1'b0;
        chk("rst.u100_before", int'(usadas_100), 1);
        @(negedge clock);
        chk("rst.pronta_before", int'(moeda_pronta), 1);
        chk("rst.tipo_before",   int'(moeda_tipo),   2);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        $display("txn reset_mid_emite pronta=%0d u100=%0d", moeda_pronta, usadas_100);
        @(negedge clock);
        reset_n = 1'b1;
        moeda_aceita = 1'b1;
        v50 = '{8'd50, 8'd5, 8'd5, 8'd5, 1, 16'b10_00_00_00_00_00_00_00, 8'd0, 8'd1, 8'd0, 8'd0, 1'b0};
        do_txn(v50, "after_rst");

`ifdef DISPENSADOR_TIMEOUT_EN
        // Ejector never accepts: watchdog ends the transaction
        moeda_aceita = 1'b0;
        n_stall = 0;
        done = 1'b0;
        start(8'd50, 8'd5, 8'd5, 8'd5);
        @(negedge clock);
        iniciar = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clock);
            if (moeda_pronta) n_stall++;
            if (concluido) done = 1'b1;
        end
        chk("wd.done",   int'(done),        1);
        chk("wd.cycles", n_stall,           255);
        chk("wd.erro",   int'(erro_troco),  1);
        chk("wd.falta",  int'(troco_falta), 50);
        chk("wd.u50",    int'(usadas_50),   0);
        chk("wd.pronta", int'(moeda_pronta), 0);
        $display("txn watchdog valor=50 emite_cycles=%0d erro=%0d falta=%0d",
                 n_stall, erro_troco, troco_falta);
`else
        n_stall = 0;
        done = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
